adder_ring_sequencer: RTL and testbench
=======================================

Name: adder_ring_sequencer

Overview:
- Autonomous measurement controller for the instrumented Sklansky adder: it sweeps a range of bit positions and, for each one, selects that bit into the ring path and enables the ring oscillator for a programmed gate window.
- It counts ring ticks and hands each (bit, count) result upstream with a valid/ready handshake.
- It is the driving and reading end of the adder's ring-select/ring-output interface, replacing manual logic-analyser sequencing by firmware.
- It sits inside the project wrapper, between the LA configuration registers and the instrumented adder.

Parameters:
WIDTH, 32, adder width; number of ring-select lines
GATE_W, 16, width of the gate-window length
CNT_W, 24, width of the tick counter
SETTLE, 2, idle cycles after selects change and before the ring is enabled

Ports:
wb_clk_i  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; launches a sweep when idle
abort  input  1  level; terminates the sweep at the next cycle
cfg_first  input  5  first bit position of the sweep
cfg_last  input  5  last bit position of the sweep, inclusive
cfg_gate  input  GATE_W  gate length in clocks; 0 is treated as 1
ring_en  output  1  enables the adder ring oscillator
ring_sel  output  WIDTH  one-hot selection of the A-input bit in the ring
out_sel  output  WIDTH  one-hot selection of the sum-output bit closing the ring
ring_tick  input  1  divided ring output; asynchronous to wb_clk_i
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
res_bit  output  5  bit position of the result
res_count  output  CNT_W  ticks counted during the gate window
busy  output  1  high from sweep start until DONE exits
done  output  1  one-cycle pulse at sweep end
err  output  1  sticky: range error or counter saturation; cleared on start

Behaviour:
- Reset values: all outputs 0, ring_sel and out_sel all zeros, FSM in IDLE.
- ring_tick synchronisation: two-flop synchroniser, then a rising-edge detector. One edge adds 1 to the count.
- Count saturation: the count saturates at all-ones. Saturation sets err.

FSM states and transitions:
- IDLE: on start, latch cfg_first, cfg_last and cfg_gate, clear err, set bit = cfg_first.
  - If cfg_first > cfg_last: set err, go to DONE. No results are produced.
  - Otherwise go to SETUP.
- SETUP: drive ring_sel = out_sel = 1 << bit, keep ring_en = 0, clear the count. Stay SETTLE cycles, then go to GATE.
- GATE: ring_en = 1. Count edges for exactly max(cfg_gate, 1) clocks, then go to DRAIN.
- DRAIN: ring_en = 0. Stay 2 cycles and keep counting edges still in the synchroniser, then go to REPORT.
- REPORT: hold res_valid = 1 with res_bit and res_count stable until res_valid & res_ready. On the handshake cycle:
  - if bit == cfg_last, go to DONE;
  - else increment bit and go to SETUP.
- DONE: pulse done for 1 cycle, clear the selects, go to IDLE.

Handshake and control rules:
- res_valid is asserted only in REPORT. No result is dropped or repeated.
- Back-pressure is unlimited; the ring stays disabled while waiting.
- start while busy is ignored. Configuration inputs are sampled only on an accepted start.
- abort in any non-IDLE state: ring_en drops the next cycle, any pending result is discarded (res_valid falls), then DONE. err is unchanged.
- abort and start in the same cycle in IDLE: start wins.
- Reset mid-operation: asynchronous return to IDLE, ring_en = 0 immediately.
- busy = (state != IDLE).
- ring_en is never asserted while the selects change: the selects are stable for SETTLE cycles before GATE.

Timing:
- Latency per bit with res_ready held high: SETTLE + max(cfg_gate,1) + 2 + 1 clocks.

Decomposition:
- Package adder_ring_pkg holds:
  - state enum: IDLE, SETUP, GATE, DRAIN, REPORT, DONE;
  - constants DRAIN_CYCLES = 2 and SYNC_STAGES = 2;
  - function onehot(bit) returning a WIDTH-bit vector.
- One sub-module, ring_tick_counter: synchroniser, edge detector, saturating counter, with clear and count-enable inputs. The FSM and handshake stay in the top.

Test Plan:
1. Basic sweep, first=3, last=5, gate=100, res_ready=1, ring_tick toggling every 4 clocks:
   - 3 results with res_bit = 3, 4, 5, each count 25 ±1;
   - done pulses once;
   - ring_sel = 0x8, 0x10, 0x20 during each respective GATE.
2. Back-pressure, res_ready low 50 cycles in REPORT:
   - res_valid, res_bit and res_count stay stable;
   - ring_en stays 0;
   - the next SETUP begins the cycle after the handshake.
3. Range and zero-gate errors:
   - first=7, last=2 → err=1, done pulses within 2 cycles, no res_valid.
   - gate=0 → GATE lasts exactly 1 clock.
4. Saturation: CNT_W=4 override, tick every 2 clocks, gate=64 → res_count = 15, err = 1.
5. Abort and start rules:
   - abort asserted mid-GATE → ring_en = 0 the next cycle, no result emitted, done pulses, busy falls.
   - start during busy → no effect.
6. Asynchronous reset in GATE: rst_n low → ring_en, busy, res_valid and the selects are 0 before the next clock edge. After release, a fresh start runs normally.

Source files
------------

// File: rtl/adder_ring_pkg.sv
// rtl/adder_ring_pkg.sv - shared states, constants and select helper for the adder ring sequencer
package adder_ring_pkg;

   localparam int MAX_WIDTH    = 32;
   localparam int DRAIN_CYCLES = 2;
   localparam int SYNC_STAGES  = 2;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_SETUP  = 3'd1;
   localparam state_t ST_GATE   = 3'd2;
   localparam state_t ST_DRAIN  = 3'd3;
   localparam state_t ST_REPORT = 3'd4;
   localparam state_t ST_DONE   = 3'd5;

   function automatic logic [MAX_WIDTH-1:0] onehot(input logic [4:0] bit_pos);
      logic [MAX_WIDTH-1:0] v;
      v          = '0;
      v[bit_pos] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ring_tick_counter.sv
// rtl/ring_tick_counter.sv - ring tick synchroniser, rising-edge detector and saturating counter
module ring_tick_counter
   import adder_ring_pkg::*;
#(
   parameter int CNT_W = 24
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_tick,
   input  logic             i_clear,
   input  logic             i_count_en,
   output logic [CNT_W-1:0] o_count,
   output logic             o_sat
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic [CNT_W-1:0]       r_count;
   logic                   r_sat;
   logic                   w_edge;
   logic                   w_full;

   assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_full  = &r_count;
   assign o_count = r_count;
   assign o_sat   = r_sat;

   // o_sat pulses when an edge arrives that the full counter can no longer absorb
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= '0;
         r_prev  <= 1'b0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_tick};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_sat  <= 1'b0;
         if (i_clear) begin
            r_count <= '0;
         end else if (i_count_en && w_edge) begin
            if (w_full) begin
               r_sat <= 1'b1;
            end else begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/adder_ring_sequencer.sv
// rtl/adder_ring_sequencer.sv - sweeps adder bit positions through the ring oscillator and reports tick counts
module adder_ring_sequencer
   import adder_ring_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int GATE_W = 16,
   parameter int CNT_W  = 24,
   parameter int SETTLE = 2
)(
   input  logic              wb_clk_i,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [4:0]        cfg_first,
   input  logic [4:0]        cfg_last,
   input  logic [GATE_W-1:0] cfg_gate,
   output logic              ring_en,
   output logic [WIDTH-1:0]  ring_sel,
   output logic [WIDTH-1:0]  out_sel,
   input  logic              ring_tick,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [4:0]        res_bit,
   output logic [CNT_W-1:0]  res_count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t              r_state;
   logic [4:0]          r_bit;
   logic [4:0]          r_last;
   logic [GATE_W-1:0]   r_gate;
   logic [GATE_W-1:0]   r_timer;
   logic [WIDTH-1:0]    r_sel;
   logic                r_err;

   logic [4:0]          w_next_bit;
   logic [MAX_WIDTH-1:0] w_first_full;
   logic [MAX_WIDTH-1:0] w_next_full;
   logic [CNT_W-1:0]    w_count;
   logic                w_sat;
   logic                w_clear;
   logic                w_count_en;

   assign w_next_bit   = r_bit + 5'd1;
   assign w_first_full = onehot(cfg_first);
   assign w_next_full  = onehot(w_next_bit);

   // Drain keeps counting so edges still inside the synchroniser are not lost
   assign w_clear    = (r_state == ST_SETUP);
   assign w_count_en = (r_state == ST_GATE) || (r_state == ST_DRAIN);

   ring_tick_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clk        (wb_clk_i),
      .rst_n      (rst_n),
      .i_tick     (ring_tick),
      .i_clear    (w_clear),
      .i_count_en (w_count_en),
      .o_count    (w_count),
      .o_sat      (w_sat)
   );

   assign ring_en   = (r_state == ST_GATE);
   assign res_valid = (r_state == ST_REPORT);
   assign busy      = (r_state != ST_IDLE);
   assign done      = (r_state == ST_DONE);
   assign ring_sel  = r_sel;
   assign out_sel   = r_sel;
   assign res_bit   = r_bit;
   assign res_count = w_count;
   assign err       = r_err;

   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_bit   <= '0;
         r_last  <= '0;
         r_gate  <= '0;
         r_timer <= '0;
         r_sel   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_sat) begin
            r_err <= 1'b1;
         end
         if (abort && (r_state != ST_IDLE) && (r_state != ST_DONE)) begin
            r_state <= ST_DONE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (start) begin
                     r_bit   <= cfg_first;
                     r_last  <= cfg_last;
                     r_gate  <= (cfg_gate == '0) ? GATE_W'(1) : cfg_gate;
                     r_timer <= '0;
                     if (cfg_first > cfg_last) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                     end else begin
                        r_err   <= 1'b0;
                        r_sel   <= w_first_full[WIDTH-1:0];
                        r_state <= ST_SETUP;
                     end
                  end
               end
               ST_SETUP: begin
                  if (r_timer == GATE_W'(SETTLE - 1)) begin
                     r_timer <= '0;
                     r_state <= ST_GATE;
                  end else begin
                     r_timer <= r_timer + GATE_W'(1);
                  end
               end
               ST_GATE: begin
                  if (r_timer == r_gate - GATE_W'(1)) begin
                     r_timer <= '0;
                     r_state <= ST_DRAIN;
                  end else begin
                     r_timer <= r_timer + GATE_W'(1);
                  end
               end
               ST_DRAIN: begin
                  if (r_timer == GATE_W'(DRAIN_CYCLES - 1)) begin
                     r_timer <= '0;
                     r_state <= ST_REPORT;
                  end else begin
                     r_timer <= r_timer + GATE_W'(1);
                  end
               end
               ST_REPORT: begin
                  if (res_ready) begin
                     if (r_bit == r_last) begin
                        r_state <= ST_DONE;
                     end else begin
                        r_bit   <= w_next_bit;
                        r_sel   <= w_next_full[WIDTH-1:0];
                        r_timer <= '0;
                        r_state <= ST_SETUP;
                     end
                  end
               end
               ST_DONE: begin
                  r_sel   <= '0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_sel   <= '0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adder_ring_sequencer.sv
// tb/tb_adder_ring_sequencer.sv - directed self-checking bench for adder_ring_sequencer
`timescale 1ns/1ps
module tb_adder_ring_sequencer;

   localparam int GATE_W = 16;

   logic              wb_clk_i;
   logic              rst_n;
   logic              start;
   logic              abort;
   logic [4:0]        cfg_first;
   logic [4:0]        cfg_last;
   logic [GATE_W-1:0] cfg_gate;
   logic              ring_tick;
   logic              res_ready;

   logic              ring_en;
   logic [31:0]       ring_sel;
   logic [31:0]       out_sel;
   logic              res_valid;
   logic [4:0]        res_bit;
   logic [23:0]       res_count;
   logic              busy;
   logic              done;
   logic              err;

   logic              s_ring_en;
   logic [31:0]       s_ring_sel;
   logic [31:0]       s_out_sel;
   logic              s_res_valid;
   logic [4:0]        s_res_bit;
   logic [3:0]        s_res_count;
   logic              s_busy;
   logic              s_done;
   logic              s_err;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_half = 0;

   logic [31:0] q_bit[$];
   logic [31:0] q_cnt[$];
   logic [31:0] q_scnt[$];
   logic [31:0] q_sel[$];
   logic [31:0] q_osel[$];
   logic [31:0] q_glen[$];
   int          done_cnt;
   int          busy_cyc;
   logic        valid_seen;

   adder_ring_sequencer u_dut (
      .wb_clk_i  (wb_clk_i),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_first (cfg_first),
      .cfg_last  (cfg_last),
      .cfg_gate  (cfg_gate),
      .ring_en   (ring_en),
      .ring_sel  (ring_sel),
      .out_sel   (out_sel),
      .ring_tick (ring_tick),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_bit   (res_bit),
      .res_count (res_count),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   // Narrow-counter twin, run in lockstep, for the saturation case
   adder_ring_sequencer #(.CNT_W(4)) u_dut_sat (
      .wb_clk_i  (wb_clk_i),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .cfg_first (cfg_first),
      .cfg_last  (cfg_last),
      .cfg_gate  (cfg_gate),
      .ring_en   (s_ring_en),
      .ring_sel  (s_ring_sel),
      .out_sel   (s_out_sel),
      .ring_tick (ring_tick),
      .res_valid (s_res_valid),
      .res_ready (res_ready),
      .res_bit   (s_res_bit),
      .res_count (s_res_count),
      .busy      (s_busy),
      .done      (s_done),
      .err       (s_err)
   );

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   initial begin
      int cnt;
      cnt = 0;
      ring_tick = 1'b0;
      forever begin
         @(negedge wb_clk_i);
         if (tick_half == 0) begin
            cnt = 0;
         end else begin
            cnt++;
            if (cnt >= tick_half) begin
               cnt = 0;
               ring_tick = ~ring_tick;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [4:0] f, input logic [4:0] l, input logic [GATE_W-1:0] g);
      cfg_first = f;
      cfg_last  = l;
      cfg_gate  = g;
      start     = 1'b1;
      @(negedge wb_clk_i);
      start     = 1'b0;
   endtask

   task automatic run_sweep(input int max_cyc);
      logic prev_en;
      int   glen;
      logic timed_out;
      q_bit.delete(); q_cnt.delete(); q_scnt.delete();
      q_sel.delete(); q_osel.delete(); q_glen.delete();
      done_cnt = 0; busy_cyc = 0; valid_seen = 1'b0;
      prev_en = 1'b0; glen = 0; timed_out = 1'b0;
      for (int c = 0; ; c++) begin
         if (c >= max_cyc) begin
            timed_out = 1'b1;
            break;
         end
         if (ring_en && !prev_en) begin
            q_sel.push_back(ring_sel);
            q_osel.push_back(out_sel);
            glen = 0;
         end
         if (ring_en) glen++;
         if (!ring_en && prev_en) q_glen.push_back(glen);
         prev_en = ring_en;
         if (res_valid) valid_seen = 1'b1;
         if (res_valid && res_ready) begin
            q_bit.push_back(res_bit);
            q_cnt.push_back(res_count);
            q_scnt.push_back(s_res_count);
         end
         if (done) done_cnt++;
         if (!busy) break;
         busy_cyc++;
         @(negedge wb_clk_i);
      end
      chk("sweep_timeout", timed_out, 0);
   endtask

   initial begin
      int n;
      int unstable;
      int en_seen;
      logic [31:0] b0;
      logic [31:0] c0;
      logic [31:0] exp_sel[3];

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
      cfg_first = '0; cfg_last = '0; cfg_gate = '0;
      exp_sel[0] = 32'h8; exp_sel[1] = 32'h10; exp_sel[2] = 32'h20;

      repeat (3) @(negedge wb_clk_i);
      chk("rst_ring_en", ring_en, 0);
      chk("rst_ring_sel", ring_sel, 0);
      chk("rst_out_sel", out_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_count", res_count, 0);
      rst_n = 1'b1;
      @(negedge wb_clk_i);

      // Basic sweep: rising tick every 4 clocks over a 100+2 clock window
      tick_half = 2;
      do_start(5'd3, 5'd5, 16'd100);
      run_sweep(1000);
      chk("t1_nres", q_bit.size(), 3);
      chk("t1_ngate", q_sel.size(), 3);
      if (q_bit.size() == 3 && q_sel.size() == 3 && q_glen.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_bit%0d", i), q_bit[i], 3 + i);
            chk($sformatf("t1_cnt%0d_range", i), (q_cnt[i] >= 24 && q_cnt[i] <= 26), 1);
            chk($sformatf("t1_sel%0d", i), q_sel[i], exp_sel[i]);
            chk($sformatf("t1_osel%0d", i), q_osel[i], exp_sel[i]);
            chk($sformatf("t1_glen%0d", i), q_glen[i], 100);
         end
      end
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_busy_cycles", busy_cyc, 316);
      chk("t1_err", err, 0);

      // Back-pressure: consumer stalls 50 cycles on the first result
      res_ready = 1'b0;
      do_start(5'd10, 5'd11, 16'd8);
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("t2_valid_reached", res_valid, 1);
      b0 = res_bit; c0 = res_count;
      unstable = 0; en_seen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge wb_clk_i);
         if (!res_valid || res_bit !== b0[4:0] || res_count !== c0[23:0]) unstable++;
         if (ring_en) en_seen++;
      end
      chk("t2_bit", b0, 10);
      chk("t2_stable", unstable, 0);
      chk("t2_ring_en_low", en_seen, 0);
      res_ready = 1'b1;
      @(negedge wb_clk_i);
      chk("t2_setup_sel", ring_sel, 32'h800);
      chk("t2_valid_drop", res_valid, 0);
      chk("t2_setup_ring_en", ring_en, 0);
      run_sweep(200);
      chk("t2_tail_cycles", busy_cyc, 14);
      chk("t2_tail_nres", q_bit.size(), 1);
      if (q_bit.size() == 1) chk("t2_tail_bit", q_bit[0], 11);
      chk("t2_done_cnt", done_cnt, 1);

      // Range error: no result, done right away
      do_start(5'd7, 5'd2, 16'd10);
      run_sweep(20);
      chk("t3_err", err, 1);
      chk("t3_done_cnt", done_cnt, 1);
      chk("t3_busy_cycles", busy_cyc, 1);
      chk("t3_no_valid", valid_seen, 0);

      // Zero gate behaves as a single-clock window; quiet ring gives count 0
      tick_half = 0;
      repeat (6) @(negedge wb_clk_i);
      do_start(5'd0, 5'd0, 16'd0);
      run_sweep(100);
      chk("t3_err_cleared", err, 0);
      chk("t3_zero_nres", q_bit.size(), 1);
      if (q_glen.size() == 1) chk("t3_zero_glen", q_glen[0], 1);
      if (q_cnt.size() == 1) chk("t3_zero_cnt", q_cnt[0], 0);
      if (q_sel.size() == 1) chk("t3_zero_sel", q_sel[0], 1);
      chk("t3_zero_busy", busy_cyc, 7);

      // Saturation: ~33 edges into a 4-bit counter
      tick_half = 1;
      do_start(5'd1, 5'd1, 16'd64);
      run_sweep(300);
      chk("t4_nres", q_scnt.size(), 1);
      if (q_scnt.size() == 1) chk("t4_sat_count", q_scnt[0], 15);
      chk("t4_sat_err", s_err, 1);
      chk("t4_wide_err", err, 0);
      if (q_cnt.size() == 1) chk("t4_wide_cnt_range", (q_cnt[0] >= 32 && q_cnt[0] <= 34), 1);

      // Abort in the middle of a gate window
      tick_half = 2;
      do_start(5'd0, 5'd31, 16'd200);
      n = 0;
      while (!ring_en && n < 20) begin
         @(negedge wb_clk_i);
         n++;
      end
      chk("t5_gate_reached", ring_en, 1);
      repeat (20) @(negedge wb_clk_i);
      abort = 1'b1;
      @(negedge wb_clk_i);
      chk("t5_abort_ring_en", ring_en, 0);
      chk("t5_abort_valid", res_valid, 0);
      chk("t5_abort_done", done, 1);
      abort = 1'b0;
      @(negedge wb_clk_i);
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_sel", ring_sel, 0);
      chk("t5_abort_err", err, 0);

      // Start while busy is ignored, including its would-be range error
      do_start(5'd4, 5'd4, 16'd10);
      do_start(5'd9, 5'd2, 16'd50);
      run_sweep(200);
      chk("t5_busy_nres", q_bit.size(), 1);
      if (q_bit.size() == 1) chk("t5_busy_bit", q_bit[0], 4);
      if (q_glen.size() == 1) chk("t5_busy_glen", q_glen[0], 10);
      chk("t5_busy_cycles", busy_cyc, 15);
      chk("t5_busy_err", err, 0);

      // Start and abort together in idle: start wins
      abort = 1'b1;
      do_start(5'd8, 5'd8, 16'd5);
      abort = 1'b0;
      chk("t5_sa_busy", busy, 1);
      chk("t5_sa_sel", ring_sel, 32'h100);
      run_sweep(100);
      chk("t5_sa_cycles", busy_cyc, 11);
      if (q_bit.size() == 1) chk("t5_sa_bit", q_bit[0], 8);
      else chk("t5_sa_nres", q_bit.size(), 1);

      // Asynchronous reset during a gate window
      do_start(5'd2, 5'd3, 16'd100);
      n = 0;
      while (!ring_en && n < 20) begin
         @(negedge wb_clk_i);
         n++;
      end
      repeat (10) @(negedge wb_clk_i);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ring_en", ring_en, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", res_valid, 0);
      chk("t6_rst_ring_sel", ring_sel, 0);
      chk("t6_rst_out_sel", out_sel, 0);
      @(negedge wb_clk_i);
      rst_n = 1'b1;
      @(negedge wb_clk_i);
      do_start(5'd6, 5'd6, 16'd20);
      run_sweep(200);
      chk("t6_nres", q_bit.size(), 1);
      if (q_bit.size() == 1) begin
         chk("t6_bit", q_bit[0], 6);
         chk("t6_cnt_range", (q_cnt[0] >= 4 && q_cnt[0] <= 7), 1);
      end
      if (q_sel.size() == 1) chk("t6_sel", q_sel[0], 32'h40);
      chk("t6_busy_cycles", busy_cyc, 26);
      chk("t6_done_cnt", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
